// File: rtl/adc_capture_pkg.sv
// Shared defaults and FSM state type for the ADC sample capture block.
package adc_capture_pkg;

  localparam int DIV_DEF       = 10;
  localparam int DW_DEF        = 12;
  localparam int DEPTH_DEF     = 8;
  localparam int CAP_PHASE_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a registered head-of-queue output.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head tracks the entry at the post-update read pointer; bypass the write when it lands there.
  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
    if (do_push && (rptr_d[AW-1:0] == wptr_q[AW-1:0])) begin
      head_d = wdata_i;
    end else begin
      head_d = mem[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
    end
  end

  assign rdata_o = head_q;

endmodule

// File: rtl/adc_sample_capture.sv
// ADC sample-clock divider, capture FSM and overflow tracking in front of a sample FIFO.
// Define ADC_CAPTURE_TWOS_COMP_EN to convert offset-binary samples to two's complement.
module adc_sample_capture
  import adc_capture_pkg::*;
#(
  parameter int DIV       = DIV_DEF,
  parameter int DW        = DW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CAP_PHASE = CAP_PHASE_DEF
) (
  input  logic          clk_16_384m,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] adc_data,
  output logic          adc_clk,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          ovf,
  input  logic          clr_ovf
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_CAP  = CW'(CAP_PHASE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          adc_clk_q, adc_clk_d;
  logic          ovf_q, ovf_d;
  cap_state_e    state_q;
  logic          push, pop, fifo_full, fifo_empty;
  logic [DW-1:0] wdata;

  always_comb begin
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    adc_clk_d = adc_clk_q ^ ((cnt_q == CNT_HALF) || (cnt_q == CNT_LAST));
  end

  always_ff @(posedge clk_16_384m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      adc_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      adc_clk_q <= adc_clk_d;
    end
  end

  // Arming waits for a period boundary so the first capture sees a full period.
  always_ff @(posedge clk_16_384m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en) state_q <= ARM;
        ARM:     if (!en) state_q <= IDLE;
                 else if (cnt_q == CNT_LAST) state_q <= RUN;
        RUN:     if (!en) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push = (state_q == RUN) && (cnt_q == CNT_CAP);
  assign pop  = m_valid && m_ready;

`ifdef ADC_CAPTURE_TWOS_COMP_EN
  assign wdata = {~adc_data[DW-1], adc_data[DW-2:0]};
`else
  assign wdata = adc_data;
`endif

  // A dropped push outranks a clear so no overflow event is ever lost.
  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_16_384m or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_16_384m),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (m_data)
  );

  assign m_valid = !fifo_empty;
  assign adc_clk = adc_clk_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture: divider, capture timing, FIFO order, overflow, reset flush.
module tb_adc_sample_capture;

  localparam int DW = 12;

  logic          clk_16_384m = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_clk;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          ovf;

  int   k;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  logic ramp = 1'b1;

  adc_sample_capture dut (
    .clk_16_384m (clk_16_384m),
    .rst_n       (rst_n),
    .en          (en),
    .adc_data    (adc_data),
    .adc_clk     (adc_clk),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .ovf         (ovf),
    .clr_ovf     (clr_ovf)
  );

  initial forever #5 clk_16_384m = ~clk_16_384m;

  function automatic logic [DW-1:0] conv(input logic [DW-1:0] x);
`ifdef ADC_CAPTURE_TWOS_COMP_EN
    return x ^ 12'h800;
`else
    return x;
`endif
  endfunction

  // k = number of clock edges since reset release; ramp value driven after edge k is 100+k.
  task automatic tick();
    @(posedge clk_16_384m);
    @(negedge clk_16_384m);
    k++;
    if (ramp) adc_data = DW'(100 + k);
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  task automatic do_reset();
    @(negedge clk_16_384m);
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0; ramp = 1'b1;
    repeat (3) @(negedge clk_16_384m);
    rst_n = 1'b1;
    k = 0;
    adc_data = DW'(100);
  endtask

  task automatic test_reset();
    @(negedge clk_16_384m);
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk_16_384m);
    chk_cnt++; if (adc_clk !== 1'b0) $display("FAIL rst_adc_clk got %b want 0", adc_clk); else pass_cnt++;
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b want 0", m_valid); else pass_cnt++;
    chk_cnt++; if (m_data !== '0) $display("FAIL rst_m_data got %h want 000", m_data); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", ovf); else pass_cnt++;
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      logic exp_clk;
      tick();
      exp_clk = ((k / 5) % 2) == 1;
      chk_cnt++; if (adc_clk !== exp_clk) $display("FAIL divider_adc_clk k=%0d got %b want %b", k, adc_clk, exp_clk); else pass_cnt++;
      chk_cnt++; if (m_valid !== 1'b0) $display("FAIL idle_m_valid k=%0d got %b want 0", k, m_valid); else pass_cnt++;
    end
  endtask

  task automatic test_capture();
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      logic exp_v;
      tick();
      exp_v = (k >= 18) && ((k % 10) == 8);
      chk_cnt++; if (m_valid !== exp_v) $display("FAIL capture_valid k=%0d got %b want %b", k, m_valid, exp_v); else pass_cnt++;
      if (exp_v) begin
        chk_cnt++; if (m_data !== conv(DW'(100 + k - 1))) $display("FAIL capture_data k=%0d got %h want %h", k, m_data, conv(DW'(100 + k - 1))); else pass_cnt++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    run_to(50);
    chk_cnt++; if (m_valid !== 1'b1) $display("FAIL hold_valid got %b want 1", m_valid); else pass_cnt++;
    chk_cnt++; if (m_data !== conv(DW'(117))) $display("FAIL hold_data got %h want %h", m_data, conv(DW'(117))); else pass_cnt++;
    run_to(97);
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_before_full_push got %b want 0", ovf); else pass_cnt++;
    run_to(98);
    chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_on_drop got %b want 1", ovf); else pass_cnt++;
    chk_cnt++; if (m_data !== conv(DW'(117))) $display("FAIL head_after_drop got %h want %h", m_data, conv(DW'(117))); else pass_cnt++;
    run_to(107);
    clr_ovf = 1'b1;
    tick();
    chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_clr_vs_overflow got %b want 1", ovf); else pass_cnt++;
    tick();
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf); else pass_cnt++;
    clr_ovf = 1'b0; en = 1'b0; m_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      chk_cnt++; if (m_valid !== 1'b1) $display("FAIL drain_valid j=%0d got %b want 1", j, m_valid); else pass_cnt++;
      chk_cnt++; if (m_data !== conv(DW'(107 + 10 * j))) $display("FAIL drain_data j=%0d got %h want %h", j, m_data, conv(DW'(107 + 10 * j))); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", m_valid); else pass_cnt++;
    m_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    run_to(97);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL full_pushpop_ovf got %b want 0", ovf); else pass_cnt++;
    chk_cnt++; if (m_valid !== 1'b1) $display("FAIL full_pushpop_valid got %b want 1", m_valid); else pass_cnt++;
    en = 1'b0; m_ready = 1'b1;
    for (int j = 2; j <= 9; j++) begin
      chk_cnt++; if (m_data !== conv(DW'(107 + 10 * j))) $display("FAIL full_pushpop_data j=%0d got %h want %h", j, m_data, conv(DW'(107 + 10 * j))); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL full_pushpop_empty got %b want 0", m_valid); else pass_cnt++;
    m_ready = 1'b0;
  endtask

  task automatic test_async_flush();
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    run_to(98);
    chk_cnt++; if (ovf !== 1'b1) $display("FAIL flush_pre_ovf got %b want 1", ovf); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL flush_m_valid got %b want 0", m_valid); else pass_cnt++;
    chk_cnt++; if (m_data !== '0) $display("FAIL flush_m_data got %h want 000", m_data); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL flush_ovf got %b want 0", ovf); else pass_cnt++;
    chk_cnt++; if (adc_clk !== 1'b0) $display("FAIL flush_adc_clk got %b want 0", adc_clk); else pass_cnt++;
  endtask

  task automatic test_twos_comp();
    do_reset();
    ramp = 1'b0;
    adc_data = 12'h800;
    en = 1'b1; m_ready = 1'b1;
    run_to(18);
    chk_cnt++; if (m_valid !== 1'b1) $display("FAIL fmt_valid got %b want 1", m_valid); else pass_cnt++;
    chk_cnt++; if (m_data !== conv(12'h800)) $display("FAIL fmt_800 got %h want %h", m_data, conv(12'h800)); else pass_cnt++;
    adc_data = 12'h7FF;
    run_to(28);
    chk_cnt++; if (m_data !== conv(12'h7FF)) $display("FAIL fmt_7ff got %h want %h", m_data, conv(12'h7FF)); else pass_cnt++;
    en = 1'b0; m_ready = 1'b0; ramp = 1'b1;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_full_pushpop();
    test_async_flush();
    test_twos_comp();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
